// File: rtl/gate_deadtime_driver.sv
// gate_deadtime_driver: dead-time protected H-bridge gate driver.
//
// The bridge command is registered once (r_cmd). Each leg then runs its own
// OFF / ON_HIGH / DEAD / ON_LOW state machine, and o_gate is registered from
// the next-state decode, so a conducting gate drops on the same edge the leg
// enters DEAD.
//
// Parameters:
//   DEAD_TIME  dead-time in i_clock cycles (0 behaves as 1)
//   PERIOD_W   width of the period counter / o_period
//
// Ports:
//   i_clock         clock, rising edge
//   i_RESET         asynchronous active-low reset
//   i_MOSFET[3:0]   bridge command: leg A = {high [0], low [2]}, leg B = {high [1], low [3]}
//   i_enable        driver enable, low forces all gates off
//   o_gate[3:0]     protected gate drive, same mapping as i_MOSFET
//   o_sigma[1:0]    registered sigma from o_gate: 01 = +1, 11 = -1, 00 = 0
//   o_period        cycles between consecutive rising edges of r_cmd[0]
//   o_period_valid  one-cycle strobe when o_period updates
//   o_fault         latched shoot-through fault
//
// Build option:
//   SHOOT_THROUGH_CHECK_EN  when defined, a same-leg high+low command latches
//                           o_fault and holds every gate off until reset.
//                           When undefined, such a leg request is ignored and
//                           o_fault is tied low.
module gate_deadtime_driver #(
    parameter int unsigned DEAD_TIME = 10,
    parameter int unsigned PERIOD_W  = 32
) (
    input  logic                i_clock,
    input  logic                i_RESET,
    input  logic [3:0]          i_MOSFET,
    input  logic                i_enable,
    output logic [3:0]          o_gate,
    output logic [1:0]          o_sigma,
    output logic [PERIOD_W-1:0] o_period,
    output logic                o_period_valid,
    output logic                o_fault
);

    localparam int unsigned DT_EFF = (DEAD_TIME == 0) ? 1 : DEAD_TIME;
    localparam int unsigned DCNT_W = (DT_EFF > 1) ? $clog2(DT_EFF) : 1;

    typedef enum logic [1:0] {
        ST_OFF     = 2'd0,
        ST_ON_HIGH = 2'd1,
        ST_DEAD    = 2'd2,
        ST_ON_LOW  = 2'd3
    } leg_state_t;

    logic [3:0]          r_cmd;
    logic                r_cmd0_d;
    logic [3:0]          gate_nxt;
    logic                kill;
    logic                rise;
    logic [PERIOD_W-1:0] period_cnt;
    logic                period_armed;

    // Shoot-through handling: kill forces both legs off for this edge.
`ifdef SHOOT_THROUGH_CHECK_EN
    logic shoot;

    assign shoot = |(r_cmd[1:0] & r_cmd[3:2]);
    assign kill  = o_fault | shoot;

    // Fault latches until reset; enable has no effect on it.
    always_ff @(posedge i_clock or negedge i_RESET) begin
        if (!i_RESET) begin
            o_fault <= 1'b0;
        end else if (shoot) begin
            o_fault <= 1'b1;
        end
    end
`else
    assign kill    = 1'b0;
    assign o_fault = 1'b0;
`endif

    // One state machine per leg; leg l drives gate bits l (high) and l+2 (low).
    for (genvar l = 0; l < 2; l++) begin : g_leg
        leg_state_t        state_q;
        leg_state_t        state_d;
        logic [DCNT_W-1:0] dcnt_q;
        logic [DCNT_W-1:0] dcnt_d;
        logic              req_h;
        logic              req_l;

        assign req_h = r_cmd[l];
        assign req_l = r_cmd[l+2];

        // State register.
        always_ff @(posedge i_clock or negedge i_RESET) begin
            if (!i_RESET) begin
                state_q <= ST_OFF;
                dcnt_q  <= '0;
            end else begin
                state_q <= state_d;
                dcnt_q  <= dcnt_d;
            end
        end

        // Next state. A high+low request on this leg (without the fault
        // option) freezes the leg, dead-time counter included.
        always_comb begin
            state_d = state_q;
            dcnt_d  = dcnt_q;
            if (kill || !i_enable) begin
                state_d = ST_OFF;
                dcnt_d  = '0;
            end else if (!(req_h && req_l)) begin
                unique case (state_q)
                    ST_OFF: begin
                        if (req_h || req_l) begin
                            state_d = ST_DEAD;
                            dcnt_d  = DCNT_W'(DT_EFF - 1);
                        end
                    end
                    ST_ON_HIGH: begin
                        if (req_l) begin
                            state_d = ST_DEAD;
                            dcnt_d  = DCNT_W'(DT_EFF - 1);
                        end else if (!req_h) begin
                            state_d = ST_OFF;
                        end
                    end
                    ST_ON_LOW: begin
                        if (req_h) begin
                            state_d = ST_DEAD;
                            dcnt_d  = DCNT_W'(DT_EFF - 1);
                        end else if (!req_l) begin
                            state_d = ST_OFF;
                        end
                    end
                    ST_DEAD: begin
                        // Full dead-time always elapses; the side is chosen
                        // only from the command present at expiry.
                        if (dcnt_q == '0) begin
                            if (req_h) begin
                                state_d = ST_ON_HIGH;
                            end else if (req_l) begin
                                state_d = ST_ON_LOW;
                            end else begin
                                state_d = ST_OFF;
                            end
                        end else begin
                            dcnt_d = dcnt_q - DCNT_W'(1);
                        end
                    end
                    default: begin
                        state_d = ST_OFF;
                        dcnt_d  = '0;
                    end
                endcase
            end
        end

        assign gate_nxt[l]   = (state_d == ST_ON_HIGH);
        assign gate_nxt[l+2] = (state_d == ST_ON_LOW);
    end

    assign rise = r_cmd[0] & ~r_cmd0_d;

    // Command register, gate/sigma outputs and period measurement.
    always_ff @(posedge i_clock or negedge i_RESET) begin
        if (!i_RESET) begin
            r_cmd          <= '0;
            r_cmd0_d       <= 1'b0;
            o_gate         <= '0;
            o_sigma        <= '0;
            o_period       <= '0;
            o_period_valid <= 1'b0;
            period_cnt     <= '0;
            period_armed   <= 1'b0;
        end else begin
            r_cmd          <= i_MOSFET;
            r_cmd0_d       <= r_cmd[0];
            o_gate         <= gate_nxt;
            o_period_valid <= 1'b0;

            if (o_gate[0] && o_gate[3]) begin
                o_sigma <= 2'b01;
            end else if (o_gate[1] && o_gate[2]) begin
                o_sigma <= 2'b11;
            end else begin
                o_sigma <= 2'b00;
            end

            // First rise after reset only starts the count.
            if (rise) begin
                period_cnt   <= '0;
                period_armed <= 1'b1;
                if (period_armed) begin
                    o_period       <= (&period_cnt) ? period_cnt : period_cnt + PERIOD_W'(1);
                    o_period_valid <= 1'b1;
                end
            end else if (!(&period_cnt)) begin
                period_cnt <= period_cnt + PERIOD_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_gate_deadtime_driver.sv
// Bench for gate_deadtime_driver: directed stimulus, a behavioural model that
// tracks each leg as "conducting side + remaining dead cycles" and measures
// periods by timestamps, a per-cycle compare against that model, and literal
// checks at hand-computed cycles.
module tb_gate_deadtime_driver;

    localparam int unsigned DT   = 10;
    localparam int unsigned PW   = 10;
    localparam longint      PMAX = (longint'(1) << PW) - 1;

    logic          clk      = 1'b0;
    logic          i_RESET  = 1'b0;
    logic [3:0]    i_MOSFET = 4'b1001;
    logic          i_enable = 1'b1;
    logic [3:0]    o_gate;
    logic [1:0]    o_sigma;
    logic [PW-1:0] o_period;
    logic          o_period_valid;
    logic          o_fault;

    int n_cmp = 0;
    int n_bad = 0;

    gate_deadtime_driver #(
        .DEAD_TIME (DT),
        .PERIOD_W  (PW)
    ) dut (
        .i_clock        (clk),
        .i_RESET        (i_RESET),
        .i_MOSFET       (i_MOSFET),
        .i_enable       (i_enable),
        .o_gate         (o_gate),
        .o_sigma        (o_sigma),
        .o_period       (o_period),
        .o_period_valid (o_period_valid),
        .o_fault        (o_fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // ---------------- behavioural model ----------------
    int         m_side [2] = '{0, 0};   // 0 none, 1 high, 2 low conducting
    int         m_dead [2] = '{0, 0};   // dead cycles still to run
    logic [3:0] m_cmd    = '0;
    logic [3:0] m_gate   = '0;
    logic [1:0] m_sigma  = '0;
    logic       m_fault  = 1'b0;
    logic       m_valid  = 1'b0;
    logic [PW-1:0] m_period = '0;
    longint     edge_n    = 0;
    longint     last_rise = 0;
    bit         armed     = 1'b0;
    bit         rise_pend = 1'b0;

    always @(posedge clk or negedge i_RESET) begin
        logic [3:0] cmd;
        bit         h;
        bit         lo;
        longint     diff;
        if (!i_RESET) begin
            m_side    = '{0, 0};
            m_dead    = '{0, 0};
            m_cmd     = '0;
            m_gate    = '0;
            m_sigma   = '0;
            m_fault   = 1'b0;
            m_valid   = 1'b0;
            m_period  = '0;
            armed     = 1'b0;
            rise_pend = 1'b0;
        end else begin
            cmd    = m_cmd;
            edge_n = edge_n + 1;

            if (m_gate[0] && m_gate[3])      m_sigma = 2'b01;
            else if (m_gate[1] && m_gate[2]) m_sigma = 2'b11;
            else                             m_sigma = 2'b00;

            // Registered command rose on the previous edge; strobe now.
            m_valid = 1'b0;
            if (rise_pend) begin
                if (armed) begin
                    diff     = (edge_n - 1) - last_rise;
                    m_period = PW'((diff > PMAX) ? PMAX : diff);
                    m_valid  = 1'b1;
                end
                armed     = 1'b1;
                last_rise = edge_n - 1;
            end
            rise_pend = i_MOSFET[0] & ~cmd[0];

`ifdef SHOOT_THROUGH_CHECK_EN
            if ((cmd[0] && cmd[2]) || (cmd[1] && cmd[3])) m_fault = 1'b1;
`endif
            for (int l = 0; l < 2; l++) begin
                h  = cmd[l];
                lo = cmd[l+2];
                if (m_fault || !i_enable) begin
                    m_side[l] = 0;
                    m_dead[l] = 0;
                end else if (h && lo) begin
                    m_side[l] = m_side[l];
                end else if (m_dead[l] > 0) begin
                    m_dead[l] = m_dead[l] - 1;
                    if (m_dead[l] == 0) m_side[l] = h ? 1 : (lo ? 2 : 0);
                end else if (m_side[l] == 0) begin
                    if (h || lo) m_dead[l] = DT;
                end else if ((m_side[l] == 1 && lo) || (m_side[l] == 2 && h)) begin
                    m_side[l] = 0;
                    m_dead[l] = DT;
                end else if ((m_side[l] == 1 && !h) || (m_side[l] == 2 && !lo)) begin
                    m_side[l] = 0;
                end
            end
            for (int l = 0; l < 2; l++) begin
                m_gate[l]   = (m_side[l] == 1) && (m_dead[l] == 0);
                m_gate[l+2] = (m_side[l] == 2) && (m_dead[l] == 0);
            end
            m_cmd = i_MOSFET;
        end
    end

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        check("model_gate",   o_gate,         m_gate);
        check("model_sigma",  o_sigma,        m_sigma);
        check("model_fault",  o_fault,        m_fault);
        check("model_valid",  o_period_valid, m_valid);
        check("model_period", o_period,       m_period);
        check("leg_a_overlap", o_gate[0] & o_gate[2], 1'b0);
        check("leg_b_overlap", o_gate[1] & o_gate[3], 1'b0);
    end

    logic [3:0] vec  [8] = '{4'b0001, 4'b0011, 4'b0000, 4'b0100, 4'b1100, 4'b1000, 4'b0110, 4'b1001};
    int         hold [8] = '{14, 3, 2, 13, 20, 1, 11, 16};

    initial begin
        step(3);
        check("reset_gate",   o_gate,         4'b0000);
        check("reset_sigma",  o_sigma,        2'b00);
        check("reset_period", o_period,       0);
        check("reset_valid",  o_period_valid, 1'b0);
        check("reset_fault",  o_fault,        1'b0);

        // Start-up: 11 cycles off, then 1001.
        i_RESET = 1'b1;
        step(11); check("startup_gate_off", o_gate, 4'b0000);
        step(1);  check("startup_gate_on",  o_gate, 4'b1001);
        step(1);  check("startup_sigma",    o_sigma, 2'b01);
        step(5);

        // Polarity swap.
        i_MOSFET = 4'b0110;
        step(1); check("swap_hold",     o_gate, 4'b1001);
        step(1); check("swap_off",      o_gate, 4'b0000);
        step(9); check("swap_dead_end", o_gate, 4'b0000);
        step(1); check("swap_on",       o_gate, 4'b0110);
        step(1); check("swap_sigma",    o_sigma, 2'b11);
        step(5);

        // Command reverts three cycles into dead-time: full dead-time still runs.
        i_MOSFET = 4'b1001;
        step(4);
        i_MOSFET = 4'b0110;
        step(7); check("abort_dead",    o_gate, 4'b0000);
        step(1); check("abort_restore", o_gate, 4'b0110);
        step(5);

        // Other side requested right at expiry: follow it, no restart.
        i_MOSFET = 4'b1001;
        step(10);
        i_MOSFET = 4'b0110;
        step(1); check("expiry_dead",   o_gate, 4'b0000);
        step(1); check("expiry_follow", o_gate, 4'b0110);
        step(3);

        // Enable drop and recovery.
        i_enable = 1'b0;
        step(1); check("disable_off", o_gate, 4'b0000);
        step(4);
        i_enable = 1'b1;
        step(10); check("enable_dead", o_gate, 4'b0000);
        step(1);  check("enable_on",   o_gate, 4'b0110);

        // Mixed leg commands, checked by the model only.
        for (int i = 0; i < 8; i++) begin
            i_MOSFET = vec[i];
            step(hold[i]);
        end

        // Period measurement from a fresh reset.
        i_MOSFET = 4'b0110;
        i_RESET  = 1'b0;
        step(2);
        check("reset2_valid", o_period_valid, 1'b0);
        i_RESET = 1'b1;
        step(20);
        for (int k = 0; k < 4; k++) begin
            i_MOSFET = 4'b1001;
            step(2);
            check("period_strobe", o_period_valid, (k > 0));
            if (k > 0) check("period_value", o_period, 500);
            step(1);
            check("period_strobe_len", o_period_valid, 1'b0);
            step(247);
            i_MOSFET = 4'b0110;
            step(250);
        end

        // Long gap saturates.
        step(1100);
        i_MOSFET = 4'b1001;
        step(2);
        check("sat_strobe", o_period_valid, 1'b1);
        check("sat_value",  o_period,       PMAX);
        step(15);

        // Same-leg high+low command.
        i_MOSFET = 4'b0101;
        step(2);
`ifdef SHOOT_THROUGH_CHECK_EN
        check("fault_set",  o_fault, 1'b1);
        check("fault_gate", o_gate,  4'b0000);
        i_MOSFET = 4'b1001;
        i_enable = 1'b0;
        step(3);
        i_enable = 1'b1;
        step(15);
        check("fault_latched",   o_fault, 1'b1);
        check("fault_gate_held", o_gate,  4'b0000);
`else
        check("nofault_flag", o_fault, 1'b0);
        check("nofault_hold", o_gate,  4'b0001);
        step(10);
        check("nofault_hold_late", o_gate, 4'b0001);
        i_MOSFET = 4'b1001;
`endif
        i_RESET = 1'b0;
        step(1);
        check("fault_cleared", o_fault, 1'b0);
        check("reset3_gate",   o_gate,  4'b0000);
        i_MOSFET = 4'b1001;
        i_RESET  = 1'b1;
        step(12); check("restart_gate_on", o_gate, 4'b1001);
        step(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
